alu_arbiter: RTL and testbench

Two-port arbiter that shares a single `execute` ALU instance between two independent requesters (port 0: integer pipeline issue, port 1: address/branch helper). Each port has a valid/ready request channel and a valid/ready response channel. Contention is resolved round-robin, one operation issues per cycle, and each result is registered into a one-entry per-port response buffer. The block owns the `execute` instance. Nothing else drives the ALU.

---
 rtl/cpu_consts.sv | 26 ++
 rtl/execute.sv | 40 ++++
 rtl/alu_arbiter.sv | 107 ++++++++++
 tb/tb_alu_arbiter.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_consts.sv
// Shared CPU constants: ALU function encoding and the packed ALU request
// that the arbiter steers into the single execute instance.
package cpu_consts;

    localparam int CPU_XLEN = 64;

    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_SLL  = 4'd2,
        OP_SRL  = 4'd3,
        OP_SRA  = 4'd4,
        OP_OR   = 4'd5,
        OP_AND  = 4'd6,
        OP_XOR  = 4'd7,
        OP_SLTU = 4'd8,
        OP_SLT  = 4'd9
    } alu_func_t;

    typedef struct packed {
        logic [CPU_XLEN-1:0] opr_a;
        logic [CPU_XLEN-1:0] opr_b;
        alu_func_t           alu_func;
    } alu_req_t;

endpackage

// File: rtl/execute.sv
// Combinational integer ALU; encodings outside alu_func_t produce zero.
module execute
    import cpu_consts::*;
#(
    parameter int XLEN = CPU_XLEN
) (
    input  logic [XLEN-1:0] opr_a_i,
    input  logic [XLEN-1:0] opr_b_i,
    input  alu_func_t       alu_func_i,
    output logic [XLEN-1:0] alu_res_o
);

    localparam int SHW = $clog2(XLEN);

    logic [SHW-1:0] shamt;
    logic           lt_u;
    logic           lt_s;

    assign shamt = opr_b_i[SHW-1:0];
    assign lt_u  = opr_a_i < opr_b_i;
    assign lt_s  = $signed(opr_a_i) < $signed(opr_b_i);

    always_comb begin
        alu_res_o = '0;
        case (alu_func_i)
            OP_ADD:  alu_res_o = opr_a_i + opr_b_i;
            OP_SUB:  alu_res_o = opr_a_i - opr_b_i;
            OP_SLL:  alu_res_o = opr_a_i << shamt;
            OP_SRL:  alu_res_o = opr_a_i >> shamt;
            OP_SRA:  alu_res_o = XLEN'($signed(opr_a_i) >>> shamt);
            OP_OR:   alu_res_o = opr_a_i | opr_b_i;
            OP_AND:  alu_res_o = opr_a_i & opr_b_i;
            OP_XOR:  alu_res_o = opr_a_i ^ opr_b_i;
            OP_SLTU: alu_res_o = {{(XLEN-1){1'b0}}, lt_u};
            OP_SLT:  alu_res_o = {{(XLEN-1){1'b0}}, lt_s};
            default: alu_res_o = '0;
        endcase
    end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin sharing of one execute ALU between two valid/ready requesters,
// with a one-entry registered response slot per port.
module alu_arbiter
    import cpu_consts::*;
#(
    parameter int XLEN = CPU_XLEN
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            req0_valid_i,
    output logic            req0_ready_o,
    input  logic [XLEN-1:0] req0_opr_a_i,
    input  logic [XLEN-1:0] req0_opr_b_i,
    input  logic [3:0]      req0_alu_func_i,
    output logic            rsp0_valid_o,
    input  logic            rsp0_ready_i,
    output logic [XLEN-1:0] rsp0_res_o,
    input  logic            req1_valid_i,
    output logic            req1_ready_o,
    input  logic [XLEN-1:0] req1_opr_a_i,
    input  logic [XLEN-1:0] req1_opr_b_i,
    input  logic [3:0]      req1_alu_func_i,
    output logic            rsp1_valid_o,
    input  logic            rsp1_ready_i,
    output logic [XLEN-1:0] rsp1_res_o
);

    logic            elig0;
    logic            elig1;
    logic            grant0;
    logic            grant1;
    logic            last_grant;
    alu_req_t        alu_req_p0;
    logic [XLEN-1:0] alu_res_p0;
    logic            vld0_p1;
    logic            vld1_p1;
    logic [XLEN-1:0] res0_p1;
    logic [XLEN-1:0] res1_p1;

    // Stage p0: eligibility, grant and ALU operand steering
    // resetn gates eligibility so no request is accepted while reset is held.
    assign elig0  = resetn && req0_valid_i && (!vld0_p1 || rsp0_ready_i);
    assign elig1  = resetn && req1_valid_i && (!vld1_p1 || rsp1_ready_i);
    // last_grant == 1 means port 1 won the previous contention, so port 0 wins now.
    assign grant0 = elig0 && (!elig1 || last_grant);
    assign grant1 = elig1 && !grant0;

    assign req0_ready_o = grant0;
    assign req1_ready_o = grant1;

    always_comb begin
        alu_req_p0 = '{opr_a: '0, opr_b: '0, alu_func: OP_ADD};
        if (grant0) begin
            alu_req_p0 = '{opr_a: req0_opr_a_i, opr_b: req0_opr_b_i,
                           alu_func: alu_func_t'(req0_alu_func_i)};
        end else if (grant1) begin
            alu_req_p0 = '{opr_a: req1_opr_a_i, opr_b: req1_opr_b_i,
                           alu_func: alu_func_t'(req1_alu_func_i)};
        end
    end

    execute #(.XLEN(XLEN)) u_execute (
        .opr_a_i    (alu_req_p0.opr_a),
        .opr_b_i    (alu_req_p0.opr_b),
        .alu_func_i (alu_req_p0.alu_func),
        .alu_res_o  (alu_res_p0)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            last_grant <= 1'b1;
        end else if (elig0 && elig1) begin
            last_grant <= grant1;
        end
    end

    // Stage p1: per-port response slots
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            vld0_p1 <= 1'b0;
            res0_p1 <= '0;
        end else if (grant0) begin
            vld0_p1 <= 1'b1;
            res0_p1 <= alu_res_p0;
        end else if (rsp0_ready_i) begin
            vld0_p1 <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            vld1_p1 <= 1'b0;
            res1_p1 <= '0;
        end else if (grant1) begin
            vld1_p1 <= 1'b1;
            res1_p1 <= alu_res_p0;
        end else if (rsp1_ready_i) begin
            vld1_p1 <= 1'b0;
        end
    end

    assign rsp0_valid_o = vld0_p1;
    assign rsp0_res_o   = res0_p1;
    assign rsp1_valid_o = vld1_p1;
    assign rsp1_res_o   = res1_p1;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed plus randomized bench for alu_arbiter against a behavioural model.
module tb_alu_arbiter;

    localparam int XLEN = 64;

    logic            clk = 1'b0;
    logic            resetn;
    logic            req0_valid, req1_valid;
    logic            req0_ready_o, req1_ready_o;
    logic [XLEN-1:0] req0_a, req0_b, req1_a, req1_b;
    logic [3:0]      req0_f, req1_f;
    logic            rsp0_valid_o, rsp1_valid_o;
    logic            rsp0_ready, rsp1_ready;
    logic [XLEN-1:0] rsp0_res_o, rsp1_res_o;

    int checks = 0;
    int errors = 0;

    // behavioural model: contents of each response slot and the last contention winner
    logic            m_v [2];
    logic [XLEN-1:0] m_res [2];
    int              m_last;
    logic            last_g0, last_g1;

    always #5 clk = ~clk;

    alu_arbiter #(.XLEN(XLEN)) dut (
        .clk(clk), .resetn(resetn),
        .req0_valid_i(req0_valid), .req0_ready_o(req0_ready_o),
        .req0_opr_a_i(req0_a), .req0_opr_b_i(req0_b), .req0_alu_func_i(req0_f),
        .rsp0_valid_o(rsp0_valid_o), .rsp0_ready_i(rsp0_ready), .rsp0_res_o(rsp0_res_o),
        .req1_valid_i(req1_valid), .req1_ready_o(req1_ready_o),
        .req1_opr_a_i(req1_a), .req1_opr_b_i(req1_b), .req1_alu_func_i(req1_f),
        .rsp1_valid_o(rsp1_valid_o), .rsp1_ready_i(rsp1_ready), .rsp1_res_o(rsp1_res_o)
    );

    function automatic logic [XLEN-1:0] ref_alu(logic [XLEN-1:0] a, logic [XLEN-1:0] b,
                                                logic [3:0] f);
        int sh;
        sh = int'(b[5:0]);
        case (f)
            4'd0: return a + b;
            4'd1: return a - b;
            4'd2: return a << sh;
            4'd3: return a >> sh;
            4'd4: return XLEN'($signed(a) >>> sh);
            4'd5: return a | b;
            4'd6: return a & b;
            4'd7: return a ^ b;
            4'd8: return (a < b) ? 64'd1 : 64'd0;
            4'd9: return ($signed(a) < $signed(b)) ? 64'd1 : 64'd0;
            default: return 64'd0;
        endcase
    endfunction

    task automatic chk(string tag, logic [XLEN-1:0] obs, logic [XLEN-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic set0(logic v, logic [XLEN-1:0] a, logic [XLEN-1:0] b, logic [3:0] f);
        req0_valid = v; req0_a = a; req0_b = b; req0_f = f;
    endtask

    task automatic set1(logic v, logic [XLEN-1:0] a, logic [XLEN-1:0] b, logic [3:0] f);
        req1_valid = v; req1_a = a; req1_b = b; req1_f = f;
    endtask

    task automatic model_reset();
        m_v[0] = 1'b0; m_v[1] = 1'b0;
        m_res[0] = '0; m_res[1] = '0;
        m_last = 1;
    endtask

    // One clock with inputs already applied at the preceding falling edge.
    task automatic cycle();
        logic e0, e1, g0, g1;
        #1;
        e0 = resetn && req0_valid && (!m_v[0] || rsp0_ready);
        e1 = resetn && req1_valid && (!m_v[1] || rsp1_ready);
        if (e0 && e1) begin
            g0 = (m_last == 1);
            g1 = !g0;
            m_last = g0 ? 0 : 1;
        end else begin
            g0 = e0;
            g1 = e1;
        end
        chk("req0_ready", {63'b0, req0_ready_o}, {63'b0, g0});
        chk("req1_ready", {63'b0, req1_ready_o}, {63'b0, g1});
        @(posedge clk);
        if (g0) begin
            m_v[0] = 1'b1; m_res[0] = ref_alu(req0_a, req0_b, req0_f);
        end else if (rsp0_ready) m_v[0] = 1'b0;
        if (g1) begin
            m_v[1] = 1'b1; m_res[1] = ref_alu(req1_a, req1_b, req1_f);
        end else if (rsp1_ready) m_v[1] = 1'b0;
        #1;
        chk("rsp0_valid", {63'b0, rsp0_valid_o}, {63'b0, m_v[0]});
        chk("rsp1_valid", {63'b0, rsp1_valid_o}, {63'b0, m_v[1]});
        if (m_v[0]) chk("rsp0_res", rsp0_res_o, m_res[0]);
        if (m_v[1]) chk("rsp1_res", rsp1_res_o, m_res[1]);
        last_g0 = g0;
        last_g1 = g1;
        @(negedge clk);
    endtask

    initial begin
        logic pend0, pend1;
        resetn = 1'b0;
        set0(1'b1, 64'd0, 64'd0, 4'd0);
        set1(1'b1, 64'd0, 64'd0, 4'd0);
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        model_reset();
        #1;
        chk("reset_rsp0_valid", {63'b0, rsp0_valid_o}, 64'd0);
        chk("reset_rsp1_valid", {63'b0, rsp1_valid_o}, 64'd0);
        chk("reset_rsp0_res", rsp0_res_o, 64'd0);
        chk("reset_rsp1_res", rsp1_res_o, 64'd0);
        chk("reset_req0_ready", {63'b0, req0_ready_o}, 64'd0);
        chk("reset_req1_ready", {63'b0, req1_ready_o}, 64'd0);
        @(negedge clk);
        @(negedge clk);
        set0(1'b0, 64'd0, 64'd0, 4'd0);
        set1(1'b0, 64'd0, 64'd0, 4'd0);
        resetn = 1'b1;
        cycle();

        // single ADD on port 0
        set0(1'b1, 64'd5, 64'd3, 4'd0);
        cycle();
        chk("add_valid", {63'b0, rsp0_valid_o}, 64'd1);
        chk("add_res", rsp0_res_o, 64'd8);
        set0(1'b0, 64'd0, 64'd0, 4'd0);
        cycle();

        // contention: SUB vs SLT, then SUB vs SLTU
        set0(1'b1, 64'd10, 64'd4, 4'd1);
        set1(1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 4'd9);
        for (int i = 0; i < 4; i++) begin
            cycle();
            chk("cont_slt_grant0", {63'b0, last_g0}, (i % 2 == 0) ? 64'd1 : 64'd0);
        end
        chk("sub_res", rsp0_res_o, 64'd6);
        chk("slt_res", rsp1_res_o, 64'd1);
        set1(1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 4'd8);
        for (int i = 0; i < 4; i++) cycle();
        chk("sltu_res", rsp1_res_o, 64'd0);
        set0(1'b0, 64'd0, 64'd0, 4'd0);
        set1(1'b0, 64'd0, 64'd0, 4'd0);
        cycle();

        // backpressure on port 0
        rsp0_ready = 1'b0;
        set0(1'b1, 64'd1, 64'd63, 4'd2);
        cycle();
        set0(1'b1, 64'd1, 64'd1, 4'd0);
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("bp_hold_res", rsp0_res_o, 64'h8000_0000_0000_0000);
        end
        rsp0_ready = 1'b1;
        cycle();
        chk("bp_second_res", rsp0_res_o, 64'd2);
        set0(1'b0, 64'd0, 64'd0, 4'd0);
        cycle();

        // drain and accept on port 1 in the same cycle
        rsp1_ready = 1'b0;
        set1(1'b1, 64'd1, 64'd2, 4'd5);
        cycle();
        rsp1_ready = 1'b1;
        set1(1'b1, 64'hF0, 64'hFF, 4'd7);
        cycle();
        chk("xor_valid", {63'b0, rsp1_valid_o}, 64'd1);
        chk("xor_res", rsp1_res_o, 64'h0F);
        set1(1'b0, 64'd0, 64'd0, 4'd0);
        cycle();

        // reset with a result still in the port 0 slot
        rsp0_ready = 1'b0;
        set0(1'b1, 64'h8000_0000_0000_0000, 64'd4, 4'd4);
        cycle();
        #2;
        resetn = 1'b0;
        model_reset();
        #1;
        chk("midrst_rsp0_valid", {63'b0, rsp0_valid_o}, 64'd0);
        chk("midrst_rsp0_res", rsp0_res_o, 64'd0);
        chk("midrst_req0_ready", {63'b0, req0_ready_o}, 64'd0);
        @(negedge clk);
        resetn = 1'b1;
        rsp0_ready = 1'b1;
        set0(1'b1, 64'd7, 64'd9, 4'd0);
        set1(1'b1, 64'd2, 64'd3, 4'd1);
        cycle();
        chk("postrst_grant0", {63'b0, rsp0_valid_o}, 64'd1);
        chk("postrst_no_grant1", {63'b0, rsp1_valid_o}, 64'd0);
        cycle();
        set0(1'b0, 64'd0, 64'd0, 4'd0);
        set1(1'b0, 64'd0, 64'd0, 4'd0);
        cycle();

        // randomized traffic; requesters hold valid and operands until accepted
        pend0 = 1'b0;
        pend1 = 1'b0;
        for (int n = 0; n < 400; n++) begin
            if (!pend0) begin
                if ($urandom_range(0, 2) != 0) begin
                    set0(1'b1, {$urandom, $urandom}, {$urandom, $urandom},
                         4'($urandom_range(0, 9)));
                    pend0 = 1'b1;
                end else set0(1'b0, 64'd0, 64'd0, 4'd0);
            end
            if (!pend1) begin
                if ($urandom_range(0, 2) != 0) begin
                    set1(1'b1, {$urandom, $urandom}, {$urandom, $urandom},
                         4'($urandom_range(0, 9)));
                    pend1 = 1'b1;
                end else set1(1'b0, 64'd0, 64'd0, 4'd0);
            end
            rsp0_ready = ($urandom_range(0, 3) != 0);
            rsp1_ready = ($urandom_range(0, 3) != 0);
            cycle();
            if (last_g0) pend0 = 1'b0;
            if (last_g1) pend1 = 1'b0;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
